// File: rtl/rom_download_router.sv
// rom_download_router
//   Splits the hps_io ioctl download byte stream into REGIONS write ports.
//   Each region sees a region-relative address, optional little-endian
//   8-to-16-bit packing, its own busy back-pressure, and sticky status.
// Ports:
//   clk_sys, reset           : clock, synchronous active-high reset
//   ioctl_download/wr/addr/dout : download stream from hps_io
//   ioctl_wait               : registered stall request back to hps_io
//   rom_busy[REGIONS]        : per-region sink not ready (bit REGIONS-1 = region 0)
//   rom_wr[REGIONS]          : one-hot write strobe (bit REGIONS-1 = region 0)
//   rom_addr, rom_data       : region-relative address and write data
//   loaded                   : download finished with no overflow
//   overflow                 : sticky, a byte fell beyond the last region
module rom_download_router #(
  parameter int REGIONS = 4,
  parameter int OUT_DW  = 8,
  parameter int OUT_AW  = 16,
  parameter logic [REGIONS*25-1:0] REGION_END = {25'h04000, 25'h0A000, 25'h0C000, 25'h10000}
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                ioctl_download,
  input  logic                ioctl_wr,
  input  logic [24:0]         ioctl_addr,
  input  logic [7:0]          ioctl_dout,
  output logic                ioctl_wait,
  input  logic [REGIONS-1:0]  rom_busy,
  output logic [REGIONS-1:0]  rom_wr,
  output logic [OUT_AW-1:0]   rom_addr,
  output logic [OUT_DW-1:0]   rom_data,
  output logic                loaded,
  output logic                overflow
);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, FLUSH = 2'd2, DONE = 2'd3} state_e;

  // Region 0 lives in the most significant slice, so the last region is the LS slice.
  localparam logic [24:0] LAST_END = REGION_END[24:0];

  function automatic logic [24:0] end_of(input int k);
    return REGION_END[(REGIONS-1-k)*25 +: 25];
  endfunction

  function automatic logic [24:0] base_of(input int k);
    if (k == 0) return 25'd0;
    else        return REGION_END[(REGIONS-k)*25 +: 25];
  endfunction

  function automatic logic [REGIONS-1:0] onehot(input logic [2:0] r);
    logic [REGIONS-1:0] v;
    for (int i = 0; i < REGIONS; i++) v[REGIONS-1-i] = (r == i[2:0]);
    return v;
  endfunction

  function automatic logic busy_of(input logic [2:0] r, input logic [REGIONS-1:0] b);
    logic s;
    s = 1'b0;
    for (int i = 0; i < REGIONS; i++) s = s | (b[REGIONS-1-i] & (r == i[2:0]));
    return s;
  endfunction

  // Byte offset -> output address (word address when packing to 16 bits).
  function automatic logic [OUT_AW-1:0] word_addr(input logic [24:0] off);
    logic [24:0] w;
    w = (OUT_DW == 16) ? (off >> 1) : off;
    return w[OUT_AW-1:0];
  endfunction

  state_e              state_q, state_d;
  logic [REGIONS-1:0]  wr_q, wr_d;
  logic [OUT_AW-1:0]   addr_q, addr_d, pend_addr_q, pend_addr_d, cand_addr;
  logic [OUT_DW-1:0]   data_q, data_d, pend_data_q, pend_data_d;
  logic                wait_q, wait_d, loaded_q, loaded_d, overflow_q, overflow_d;
  logic                hold_valid_q, hold_valid_d, hold_hi_q, hold_hi_d;
  logic [7:0]          hold_byte_q, hold_byte_d;
  logic [2:0]          hold_region_q, hold_region_d, pend_region_q, pend_region_d;
  logic [2:0]          cand_region, dec_region;
  logic [24:0]         hold_off_q, hold_off_d, dec_off;
  logic                pend_valid_q, pend_valid_d, cand_valid, dec_over;
  logic [15:0]         cand_data;

  assign rom_wr     = wr_q;
  assign rom_addr   = addr_q;
  assign rom_data   = data_q;
  assign ioctl_wait = wait_q;
  assign loaded     = loaded_q;
  assign overflow   = overflow_q;
  assign dec_over   = (ioctl_addr >= LAST_END);

  // Region decode: iterate downwards so the lowest matching region wins.
  always_comb begin
    dec_region = 3'd0;
    dec_off    = 25'd0;
    for (int k = REGIONS-1; k >= 0; k--) begin
      if (ioctl_addr < end_of(k)) begin
        dec_region = k[2:0];
        dec_off    = ioctl_addr - base_of(k);
      end else begin
        dec_region = dec_region;
        dec_off    = dec_off;
      end
    end
  end

  // State register plus all datapath flops.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q       <= IDLE;
      wr_q          <= '0;
      addr_q        <= '0;
      data_q        <= '0;
      wait_q        <= 1'b0;
      loaded_q      <= 1'b0;
      overflow_q    <= 1'b0;
      hold_valid_q  <= 1'b0;
      hold_hi_q     <= 1'b0;
      hold_byte_q   <= 8'h00;
      hold_region_q <= 3'd0;
      hold_off_q    <= 25'd0;
      pend_valid_q  <= 1'b0;
      pend_region_q <= 3'd0;
      pend_addr_q   <= '0;
      pend_data_q   <= '0;
    end else begin
      state_q       <= state_d;
      wr_q          <= wr_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      wait_q        <= wait_d;
      loaded_q      <= loaded_d;
      overflow_q    <= overflow_d;
      hold_valid_q  <= hold_valid_d;
      hold_hi_q     <= hold_hi_d;
      hold_byte_q   <= hold_byte_d;
      hold_region_q <= hold_region_d;
      hold_off_q    <= hold_off_d;
      pend_valid_q  <= pend_valid_d;
      pend_region_q <= pend_region_d;
      pend_addr_q   <= pend_addr_d;
      pend_data_q   <= pend_data_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = ioctl_download ? LOAD : IDLE;
      LOAD:    state_d = ioctl_download ? LOAD : FLUSH;
      FLUSH:   state_d = (!pend_valid_q && !hold_valid_q) ? DONE : FLUSH;
      DONE:    state_d = ioctl_download ? LOAD : DONE;
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath logic: build at most one write candidate per cycle, then
  // either launch it on rom_wr or park it as pending while its sink is busy.
  always_comb begin
    wr_d          = '0;
    addr_d        = addr_q;
    data_d        = data_q;
    wait_d        = 1'b0;
    overflow_d    = overflow_q;
    hold_valid_d  = hold_valid_q;
    hold_hi_d     = hold_hi_q;
    hold_byte_d   = hold_byte_q;
    hold_region_d = hold_region_q;
    hold_off_d    = hold_off_q;
    pend_valid_d  = pend_valid_q;
    pend_region_d = pend_region_q;
    pend_addr_d   = pend_addr_q;
    pend_data_d   = pend_data_q;
    cand_valid    = 1'b0;
    cand_region   = 3'd0;
    cand_addr     = '0;
    cand_data     = 16'h0000;
    case (state_q)
      IDLE, DONE: begin
        if (ioctl_download) begin
          overflow_d   = 1'b0;
          hold_valid_d = 1'b0;
          hold_hi_d    = 1'b0;
          pend_valid_d = 1'b0;
        end else begin
          overflow_d = overflow_q;
        end
      end
      LOAD, FLUSH: begin
        if (pend_valid_q) begin
          // Stalled write: wait stays high through the issuing cycle.
          wait_d = 1'b1;
          if (!busy_of(pend_region_q, rom_busy)) begin
            wr_d         = onehot(pend_region_q);
            addr_d       = pend_addr_q;
            data_d       = pend_data_q;
            pend_valid_d = 1'b0;
          end else begin
            pend_valid_d = 1'b1;
          end
        end else if (hold_hi_q) begin
          // Lone high byte left over after flushing an unpaired low byte.
          wait_d       = 1'b1;
          hold_valid_d = 1'b0;
          hold_hi_d    = 1'b0;
          cand_valid   = 1'b1;
          cand_region  = hold_region_q;
          cand_addr    = word_addr(hold_off_q);
          cand_data    = {hold_byte_q, 8'h00};
        end else if (state_q == LOAD) begin
          // The byte coinciding with the download falling edge is still taken here.
          if (ioctl_wr && !wait_q) begin
            if (dec_over) begin
              overflow_d = 1'b1;
            end else if (OUT_DW == 16) begin
              if (!dec_off[0]) begin
                if (hold_valid_q) begin
                  cand_valid  = 1'b1;
                  cand_region = hold_region_q;
                  cand_addr   = word_addr(hold_off_q);
                  cand_data   = {8'h00, hold_byte_q};
                end else begin
                  cand_valid = 1'b0;
                end
                hold_valid_d  = 1'b1;
                hold_hi_d     = 1'b0;
                hold_byte_d   = ioctl_dout;
                hold_region_d = dec_region;
                hold_off_d    = dec_off;
              end else if (hold_valid_q && hold_region_q == dec_region &&
                           dec_off == hold_off_q + 25'd1) begin
                cand_valid   = 1'b1;
                cand_region  = dec_region;
                cand_addr    = word_addr(dec_off);
                cand_data    = {ioctl_dout, hold_byte_q};
                hold_valid_d = 1'b0;
              end else if (hold_valid_q) begin
                // Unpaired low byte goes out first; the odd byte follows next
                // cycle, so the source is stalled for one write slot.
                cand_valid    = 1'b1;
                cand_region   = hold_region_q;
                cand_addr     = word_addr(hold_off_q);
                cand_data     = {8'h00, hold_byte_q};
                hold_valid_d  = 1'b1;
                hold_hi_d     = 1'b1;
                hold_byte_d   = ioctl_dout;
                hold_region_d = dec_region;
                hold_off_d    = dec_off;
                wait_d        = 1'b1;
              end else begin
                cand_valid  = 1'b1;
                cand_region = dec_region;
                cand_addr   = word_addr(dec_off);
                cand_data   = {ioctl_dout, 8'h00};
              end
            end else begin
              cand_valid  = 1'b1;
              cand_region = dec_region;
              cand_addr   = word_addr(dec_off);
              cand_data   = {8'h00, ioctl_dout};
            end
          end else begin
            cand_valid = 1'b0;
          end
        end else if (hold_valid_q) begin
          hold_valid_d = 1'b0;
          cand_valid   = 1'b1;
          cand_region  = hold_region_q;
          cand_addr    = word_addr(hold_off_q);
          cand_data    = {8'h00, hold_byte_q};
        end else begin
          cand_valid = 1'b0;
        end
      end
      default: begin
        cand_valid = 1'b0;
      end
    endcase
    if (cand_valid) begin
      if (busy_of(cand_region, rom_busy)) begin
        pend_valid_d  = 1'b1;
        pend_region_d = cand_region;
        pend_addr_d   = cand_addr;
        pend_data_d   = cand_data[OUT_DW-1:0];
        wait_d        = 1'b1;
      end else begin
        wr_d   = onehot(cand_region);
        addr_d = cand_addr;
        data_d = cand_data[OUT_DW-1:0];
      end
    end else begin
      wr_d = wr_d;
    end
    loaded_d = (state_d == DONE) && !overflow_q;
  end

endmodule

// File: tb/tb_rom_download_router.sv
module tb_rom_download_router;

  logic        clk = 1'b0;
  logic        reset, dl, wr;
  logic [24:0] addr;
  logic [7:0]  dout;
  logic [3:0]  busy8, busy16;
  logic [3:0]  w8, w16;
  logic [15:0] a8, a16, d16;
  logic [7:0]  d8;
  logic        wait8, wait16, ld8, ld16, ov8, ov16;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  rom_download_router #(.REGIONS(4), .OUT_DW(8), .OUT_AW(16)) u8 (
    .clk_sys(clk), .reset(reset), .ioctl_download(dl), .ioctl_wr(wr),
    .ioctl_addr(addr), .ioctl_dout(dout), .ioctl_wait(wait8), .rom_busy(busy8),
    .rom_wr(w8), .rom_addr(a8), .rom_data(d8), .loaded(ld8), .overflow(ov8));

  rom_download_router #(.REGIONS(4), .OUT_DW(16), .OUT_AW(16)) u16 (
    .clk_sys(clk), .reset(reset), .ioctl_download(dl), .ioctl_wr(wr),
    .ioctl_addr(addr), .ioctl_dout(dout), .ioctl_wait(wait16), .rom_busy(busy16),
    .rom_wr(w16), .rom_addr(a16), .rom_data(d16), .loaded(ld16), .overflow(ov16));

  typedef struct {
    logic        dl;
    logic        wr;
    logic [24:0] addr;
    logic [7:0]  dout;
    logic [3:0]  busy;
    logic [3:0]  e_wr;
    logic [15:0] e_addr;
    logic [7:0]  e_data;
    logic        e_wait;
    logic        e_loaded;
    logic        e_ovf;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic d, input logic w, input logic [24:0] a,
                              input logic [7:0] b, input logic [3:0] bz,
                              input logic [3:0] ew, input logic [15:0] ea,
                              input logic [7:0] ed, input logic ewt,
                              input logic eld, input logic eov);
    vec_t v;
    v.dl = d; v.wr = w; v.addr = a; v.dout = b; v.busy = bz;
    v.e_wr = ew; v.e_addr = ea; v.e_data = ed; v.e_wait = ewt;
    v.e_loaded = eld; v.e_ovf = eov;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic put(input logic d, input logic w, input logic [24:0] a, input logic [7:0] b);
    dl = d; wr = w; addr = a; dout = b;
    @(posedge clk);
    #1;
  endtask

  task automatic chk16(input string tag, input logic [3:0] ew, input logic [15:0] ea,
                       input logic [15:0] ed, input logic ewt);
    chk({tag, " wr16"}, {28'd0, w16}, {28'd0, ew});
    chk({tag, " wait16"}, {31'd0, wait16}, {31'd0, ewt});
    if (ew != 4'h0) begin
      chk({tag, " addr16"}, {16'd0, a16}, {16'd0, ea});
      chk({tag, " data16"}, {16'd0, d16}, {16'd0, ed});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // 8-bit vectors: each row's expectations are the registered outputs one edge later.
    vecs[0]  = mk(1'b1, 1'b0, 25'h0000000, 8'h00, 4'h0, 4'b0000, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0);
    vecs[1]  = mk(1'b1, 1'b1, 25'h0003FFF, 8'h11, 4'h0, 4'b1000, 16'h3FFF, 8'h11, 1'b0, 1'b0, 1'b0);
    vecs[2]  = mk(1'b1, 1'b1, 25'h0004000, 8'h22, 4'h0, 4'b0100, 16'h0000, 8'h22, 1'b0, 1'b0, 1'b0);
    vecs[3]  = mk(1'b1, 1'b1, 25'h0009FFF, 8'h33, 4'h0, 4'b0100, 16'h5FFF, 8'h33, 1'b0, 1'b0, 1'b0);
    vecs[4]  = mk(1'b1, 1'b1, 25'h000A000, 8'h44, 4'h0, 4'b0010, 16'h0000, 8'h44, 1'b0, 1'b0, 1'b0);
    vecs[5]  = mk(1'b1, 1'b1, 25'h000FFFF, 8'h55, 4'h0, 4'b0001, 16'h3FFF, 8'h55, 1'b0, 1'b0, 1'b0);
    vecs[6]  = mk(1'b1, 1'b0, 25'h0000000, 8'h00, 4'h0, 4'b0000, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0);
    vecs[7]  = mk(1'b1, 1'b1, 25'h0000010, 8'h66, 4'h8, 4'b0000, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0);
    vecs[8]  = mk(1'b1, 1'b0, 25'h0000000, 8'h00, 4'h8, 4'b0000, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0);
    vecs[9]  = mk(1'b1, 1'b1, 25'h0004001, 8'h77, 4'h8, 4'b0000, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0);
    vecs[10] = mk(1'b1, 1'b0, 25'h0000000, 8'h00, 4'h8, 4'b0000, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0);
    vecs[11] = mk(1'b1, 1'b0, 25'h0000000, 8'h00, 4'h8, 4'b0000, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0);
    vecs[12] = mk(1'b1, 1'b0, 25'h0000000, 8'h00, 4'h0, 4'b1000, 16'h0010, 8'h66, 1'b1, 1'b0, 1'b0);
    vecs[13] = mk(1'b1, 1'b0, 25'h0000000, 8'h00, 4'h0, 4'b0000, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0);
    vecs[14] = mk(1'b1, 1'b1, 25'h000C000, 8'h88, 4'h8, 4'b0001, 16'h0000, 8'h88, 1'b0, 1'b0, 1'b0);
    vecs[15] = mk(1'b1, 1'b1, 25'h0010000, 8'h99, 4'h0, 4'b0000, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b1);
    vecs[16] = mk(1'b1, 1'b1, 25'h1FFFFFF, 8'h9A, 4'h0, 4'b0000, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b1);
    vecs[17] = mk(1'b0, 1'b1, 25'h0004005, 8'hAB, 4'h0, 4'b0100, 16'h0005, 8'hAB, 1'b0, 1'b0, 1'b1);
    vecs[18] = mk(1'b0, 1'b0, 25'h0000000, 8'h00, 4'h0, 4'b0000, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b1);
    vecs[19] = mk(1'b0, 1'b0, 25'h0000000, 8'h00, 4'h0, 4'b0000, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b1);
    vecs[20] = mk(1'b1, 1'b0, 25'h0000000, 8'h00, 4'h0, 4'b0000, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0);
    vecs[21] = mk(1'b0, 1'b1, 25'h0000001, 8'h01, 4'h0, 4'b1000, 16'h0001, 8'h01, 1'b0, 1'b0, 1'b0);
    vecs[22] = mk(1'b0, 1'b0, 25'h0000000, 8'h00, 4'h0, 4'b0000, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b0);
    vecs[23] = mk(1'b0, 1'b0, 25'h0000000, 8'h00, 4'h0, 4'b0000, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b0);

    reset = 1'b1; dl = 1'b0; wr = 1'b0; addr = 25'd0; dout = 8'h00;
    busy8 = 4'h0; busy16 = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset wr8", {28'd0, w8}, 32'd0);
    chk("reset addr8", {16'd0, a8}, 32'd0);
    chk("reset data8", {24'd0, d8}, 32'd0);
    chk("reset wait8", {31'd0, wait8}, 32'd0);
    chk("reset loaded8", {31'd0, ld8}, 32'd0);
    chk("reset overflow8", {31'd0, ov8}, 32'd0);
    chk("reset data16", {16'd0, d16}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      dl = vecs[i].dl; wr = vecs[i].wr; addr = vecs[i].addr;
      dout = vecs[i].dout; busy8 = vecs[i].busy;
      @(posedge clk);
      #1;
      chk($sformatf("row%0d wr8", i), {28'd0, w8}, {28'd0, vecs[i].e_wr});
      chk($sformatf("row%0d wait8", i), {31'd0, wait8}, {31'd0, vecs[i].e_wait});
      chk($sformatf("row%0d loaded8", i), {31'd0, ld8}, {31'd0, vecs[i].e_loaded});
      chk($sformatf("row%0d overflow8", i), {31'd0, ov8}, {31'd0, vecs[i].e_ovf});
      if (vecs[i].e_wr != 4'h0) begin
        chk($sformatf("row%0d addr8", i), {16'd0, a8}, {16'd0, vecs[i].e_addr});
        chk($sformatf("row%0d data8", i), {24'd0, d8}, {24'd0, vecs[i].e_data});
      end
    end
    wr = 1'b0; busy8 = 4'h0;

    // 16-bit packing: a clean pair produces a single write.
    reset = 1'b1;
    put(1'b0, 1'b0, 25'd0, 8'h00);
    reset = 1'b0;
    put(1'b1, 1'b0, 25'd0, 8'h00);
    put(1'b1, 1'b1, 25'h000A000, 8'hAA);
    chk16("pair low", 4'b0000, 16'h0000, 16'h0000, 1'b0);
    put(1'b1, 1'b1, 25'h000A001, 8'hBB);
    chk16("pair high", 4'b0010, 16'h0000, 16'hBBAA, 1'b0);
    put(1'b1, 1'b0, 25'd0, 8'h00);
    chk16("pair after", 4'b0000, 16'h0000, 16'h0000, 1'b0);

    // Lone byte flushed when the download ends.
    put(1'b1, 1'b1, 25'h000C002, 8'h5C);
    chk16("lone hold", 4'b0000, 16'h0000, 16'h0000, 1'b0);
    put(1'b0, 1'b0, 25'd0, 8'h00);
    chk16("lone fall", 4'b0000, 16'h0000, 16'h0000, 1'b0);
    put(1'b0, 1'b0, 25'd0, 8'h00);
    chk16("lone flush", 4'b0001, 16'h0001, 16'h005C, 1'b0);
    put(1'b0, 1'b0, 25'd0, 8'h00);
    chk("lone loaded16", {31'd0, ld16}, 32'd1);

    // Reset while a low byte is held: nothing written, held byte forgotten.
    put(1'b1, 1'b0, 25'd0, 8'h00);
    put(1'b1, 1'b1, 25'h0000000, 8'h12);
    chk16("rst hold", 4'b0000, 16'h0000, 16'h0000, 1'b0);
    reset = 1'b1;
    put(1'b1, 1'b0, 25'd0, 8'h00);
    reset = 1'b0;
    chk16("rst out", 4'b0000, 16'h0000, 16'h0000, 1'b0);
    chk("rst addr16", {16'd0, a16}, 32'd0);
    chk("rst data16", {16'd0, d16}, 32'd0);
    chk("rst loaded16", {31'd0, ld16}, 32'd0);
    put(1'b0, 1'b0, 25'd0, 8'h00);
    put(1'b0, 1'b0, 25'd0, 8'h00);
    chk16("rst idle", 4'b0000, 16'h0000, 16'h0000, 1'b0);
    chk("rst idle loaded16", {31'd0, ld16}, 32'd0);
    put(1'b1, 1'b0, 25'd0, 8'h00);
    put(1'b1, 1'b1, 25'h0000001, 8'h34);
    chk16("rst restart", 4'b1000, 16'h0000, 16'h3400, 1'b0);

    // Region crossing mid-pair: flush the low byte, then the odd byte alone.
    put(1'b1, 1'b1, 25'h0004002, 8'h56);
    chk16("cross hold", 4'b0000, 16'h0000, 16'h0000, 1'b0);
    put(1'b1, 1'b1, 25'h000A001, 8'h78);
    chk16("cross flush", 4'b0100, 16'h0001, 16'h0056, 1'b1);
    put(1'b1, 1'b0, 25'd0, 8'h00);
    chk16("cross odd", 4'b0010, 16'h0000, 16'h7800, 1'b1);
    put(1'b1, 1'b0, 25'd0, 8'h00);
    chk16("cross idle", 4'b0000, 16'h0000, 16'h0000, 1'b0);

    // Even byte while a low byte is held flushes the old one.
    put(1'b1, 1'b1, 25'h0000004, 8'h9A);
    put(1'b1, 1'b1, 25'h0000006, 8'hBC);
    chk16("even flush", 4'b1000, 16'h0002, 16'h009A, 1'b0);
    put(1'b0, 1'b0, 25'd0, 8'h00);
    put(1'b0, 1'b0, 25'd0, 8'h00);
    chk16("even end", 4'b1000, 16'h0003, 16'h00BC, 1'b0);
    put(1'b0, 1'b0, 25'd0, 8'h00);
    chk("even loaded16", {31'd0, ld16}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
